// File: rtl/lsb_serial_tx_pkg.sv
// Shared types for the LSB-first serial transmitter: FSM state encoding and default word width.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } tx_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/lsb_serial_tx_if.sv
// Load and serial-beat handshake bundle for lsb_serial_tx.
// The slave modport is the transmitter view; master is the upstream/downstream environment.
interface lsb_serial_tx_if #(
  parameter int WIDTH = serial_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0] dataIn;
  logic             loadValid;
  logic             loadReady;
  logic             bitOut;
  logic             bitValid;
  logic             bitReady;
  logic             frameStart;
  logic             frameLast;

  modport master (
    output dataIn, loadValid, bitReady,
    input  loadReady, bitOut, bitValid, frameStart, frameLast
  );

  modport slave (
    input  dataIn, loadValid, bitReady,
    output loadReady, bitOut, bitValid, frameStart, frameLast
  );

endinterface

// File: rtl/lsb_serial_tx.sv
// LSB-first bit-serial transmitter with frame start/last markers and zero-gap frame chaining.
// Optional trailing even-parity beat when LSB_SERIAL_TX_PARITY_EN is defined.
module lsb_serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  lsb_serial_tx_if.slave       bus
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1'b1);

  tx_state_t        state_r;
  tx_state_t        state_s;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_s;
  logic             bit_out_r;
  logic             bit_out_s;
  logic             bit_valid_r;
  logic             bit_valid_s;
  logic             frame_start_r;
  logic             frame_start_s;
  logic             frame_last_r;
  logic             frame_last_s;
  logic             xfer_s;
  logic             load_ready_s;
  logic             load_s;

`ifdef LSB_SERIAL_TX_PARITY_EN
  logic par_r;
  logic par_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] data);
    return ^data;
  endfunction
`endif

  assign xfer_s       = bit_valid_r & bus.bitReady;
  assign load_ready_s = (state_r == IDLE) | (xfer_s & frame_last_r);
  assign load_s       = bus.loadValid & load_ready_s;

  assign bus.loadReady  = load_ready_s;
  assign bus.bitOut     = bit_out_r;
  assign bus.bitValid   = bit_valid_r;
  assign bus.frameStart = frame_start_r;
  assign bus.frameLast  = frame_last_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; a load on the final beat chains straight into the next frame
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_s) state_s = SHIFT;
        else        state_s = IDLE;
      end
      SHIFT: begin
        if (xfer_s && (cnt_r == LAST_CNT)) begin
`ifdef LSB_SERIAL_TX_PARITY_EN
          state_s = PAR;
`else
          if (load_s) state_s = SHIFT;
          else        state_s = IDLE;
`endif
        end else begin
          state_s = SHIFT;
        end
      end
`ifdef LSB_SERIAL_TX_PARITY_EN
      PAR: begin
        if (xfer_s) begin
          if (load_s) state_s = SHIFT;
          else        state_s = IDLE;
        end else begin
          state_s = PAR;
        end
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // Datapath next values and the beat outputs implied by the next state
  always_comb begin
    shift_s       = shift_r;
    cnt_s         = cnt_r;
    bit_out_s     = 1'b0;
    bit_valid_s   = 1'b0;
    frame_start_s = 1'b0;
    frame_last_s  = 1'b0;
`ifdef LSB_SERIAL_TX_PARITY_EN
    par_s         = par_r;
`endif
    if (load_s) begin
      shift_s = bus.dataIn;
      cnt_s   = '0;
`ifdef LSB_SERIAL_TX_PARITY_EN
      par_s   = even_parity(bus.dataIn);
`endif
    end else if (xfer_s && (state_r == SHIFT)) begin
      shift_s = {1'b0, shift_r[WIDTH-1:1]};
      cnt_s   = cnt_r + CNT_ONE;
    end else begin
      shift_s = shift_r;
      cnt_s   = cnt_r;
    end
    bit_valid_s = (state_s != IDLE);
    case (state_s)
      SHIFT: begin
        bit_out_s     = shift_s[0];
        frame_start_s = (cnt_s == '0);
`ifdef LSB_SERIAL_TX_PARITY_EN
        frame_last_s  = 1'b0;
`else
        frame_last_s  = (cnt_s == LAST_CNT);
`endif
      end
`ifdef LSB_SERIAL_TX_PARITY_EN
      PAR: begin
        bit_out_s     = par_s;
        frame_start_s = 1'b0;
        frame_last_s  = 1'b1;
      end
`endif
      default: begin
        bit_out_s     = 1'b0;
        frame_start_s = 1'b0;
        frame_last_s  = 1'b0;
      end
    endcase
  end

  // Datapath and registered beat outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r       <= '0;
      cnt_r         <= '0;
      bit_out_r     <= 1'b0;
      bit_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      frame_last_r  <= 1'b0;
`ifdef LSB_SERIAL_TX_PARITY_EN
      par_r         <= 1'b0;
`endif
    end else begin
      shift_r       <= shift_s;
      cnt_r         <= cnt_s;
      bit_out_r     <= bit_out_s;
      bit_valid_r   <= bit_valid_s;
      frame_start_r <= frame_start_s;
      frame_last_r  <= frame_last_s;
`ifdef LSB_SERIAL_TX_PARITY_EN
      par_r         <= par_s;
`endif
    end
  end

endmodule
